// File: rtl/ttl_74161_cen_counter.sv
// 74LS161-style synchronous counter, cascadable to BLOCKS 4-bit stages and clocked by Cen strobes.
// Optional TC strobe output enabled by defining TTL74161_TC_STROBE_EN.
module ttl_74161_cen_counter #(
  parameter int BLOCKS = 1
) (
  input  logic                  Clk,
  input  logic                  CLRn,
  input  logic                  Cen,
  input  logic                  LOADn,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [4*BLOCKS-1:0]   D,
  output logic [4*BLOCKS-1:0]   Q,
  output logic                  RCO
`ifdef TTL74161_TC_STROBE_EN
  ,
  output logic                  TC
`endif
);

  logic              last_cen;
  logic              cen_event;
  logic [BLOCKS-1:0] stage_max;
  logic [BLOCKS-1:0] ent;
  logic [BLOCKS-1:0] rco;

  assign cen_event = Cen & ~last_cen;

  // ent is built from the per-stage all-ones flags rather than the previous rco,
  // so the carry chain is a flat AND with no self-referencing vector.
  for (genvar i = 0; i < BLOCKS; i++) begin : g_stage
    assign stage_max[i] = &Q[4*i +: 4];
    if (i == 0) begin : g_first
      assign ent[i] = ENT;
    end else begin : g_rest
      assign ent[i] = ENT & (&stage_max[i-1:0]);
    end
    assign rco[i] = ent[i] & stage_max[i];
  end

  assign RCO = rco[BLOCKS-1];

  always_ff @(posedge Clk or negedge CLRn) begin
    if (!CLRn) begin
      Q        <= '0;
      last_cen <= 1'b1;
    end else begin
      last_cen <= Cen;
      if (cen_event) begin
        if (!LOADn) begin
          Q <= D;
        end else begin
          for (int i = 0; i < BLOCKS; i++) begin
            if (ENP && ent[i]) begin
              Q[4*i +: 4] <= Q[4*i +: 4] + 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef TTL74161_TC_STROBE_EN
  // Registered off the pre-event chain state, so it rises with the wrap and lasts one Clk.
  always_ff @(posedge Clk or negedge CLRn) begin
    if (!CLRn) begin
      TC <= 1'b0;
    end else begin
      TC <= cen_event & LOADn & ENP & RCO;
    end
  end
`endif

endmodule

// File: tb/tb_ttl_74161_cen_counter.sv
// Directed testbench for ttl_74161_cen_counter: one 4-bit and one 8-bit instance sharing controls.
module tb_ttl_74161_cen_counter;

  logic       Clk;
  logic       CLRn;
  logic       Cen;
  logic       LOADn;
  logic       ENP;
  logic       ENT;
  logic [3:0] d1;
  logic [7:0] d2;
  logic [3:0] q1;
  logic [7:0] q2;
  logic       rco1;
  logic       rco2;
`ifdef TTL74161_TC_STROBE_EN
  logic       tc1;
  logic       tc2;
`endif

  int vectors;
  int miscompares;

  ttl_74161_cen_counter #(.BLOCKS(1)) dut1 (
    .Clk(Clk), .CLRn(CLRn), .Cen(Cen), .LOADn(LOADn), .ENP(ENP), .ENT(ENT),
    .D(d1), .Q(q1), .RCO(rco1)
`ifdef TTL74161_TC_STROBE_EN
    , .TC(tc1)
`endif
  );

  ttl_74161_cen_counter #(.BLOCKS(2)) dut2 (
    .Clk(Clk), .CLRn(CLRn), .Cen(Cen), .LOADn(LOADn), .ENP(ENP), .ENT(ENT),
    .D(d2), .Q(q2), .RCO(rco2)
`ifdef TTL74161_TC_STROBE_EN
    , .TC(tc2)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One Cen low-to-high transition, seen by exactly one posedge; returns at the negedge after it.
  task automatic cen_pulse();
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk) Cen = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      vectors++;
      if (q1 !== 4'h0 || rco1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: q1=%h rco1=%b expected q1=0 rco1=0", i, q1, rco1);
      end
      Cen = ~Cen;
    end
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk);
    CLRn = 1'b1; LOADn = 1'b1; ENP = 1'b1; ENT = 1'b1;
    @(negedge Clk);
    vectors++;
    if (q1 !== 4'h0 || q2 !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_release_cen_high: q1=%h q2=%h expected 0 and 00", q1, q2);
    end
    Cen = 1'b0;
  endtask

  task automatic test_count_wrap();
    LOADn = 1'b1; ENP = 1'b1; ENT = 1'b1;
    repeat (15) cen_pulse();
    vectors++;
    if (q1 !== 4'hF || rco1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL count_15: q1=%h rco1=%b expected q1=f rco1=1", q1, rco1);
    end
    cen_pulse();
    vectors++;
    if (q1 !== 4'h0 || rco1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL count_16_wrap: q1=%h rco1=%b expected q1=0 rco1=0", q1, rco1);
    end
    cen_pulse();
    vectors++;
    if (q1 !== 4'h1) begin
      miscompares++;
      $display("[TB] FAIL count_17: q1=%h expected 1", q1);
    end
  endtask

  task automatic test_load_priority();
    LOADn = 1'b0; d1 = 4'h3;
    cen_pulse();
    vectors++;
    if (q1 !== 4'h3) begin
      miscompares++;
      $display("[TB] FAIL load_3: q1=%h expected 3", q1);
    end
    ENP = 1'b0; ENT = 1'b0; d1 = 4'hC;
    cen_pulse();
    vectors++;
    if (q1 !== 4'hC) begin
      miscompares++;
      $display("[TB] FAIL load_c_enables_off: q1=%h expected c", q1);
    end
    d1 = 4'h5;
    repeat (3) @(negedge Clk);
    vectors++;
    if (q1 !== 4'hC) begin
      miscompares++;
      $display("[TB] FAIL load_without_cen: q1=%h expected c", q1);
    end
  endtask

  task automatic test_enables();
    LOADn = 1'b0; d1 = 4'hF;
    cen_pulse();
    LOADn = 1'b1; ENP = 1'b0; ENT = 1'b1;
    cen_pulse();
    vectors++;
    if (q1 !== 4'hF || rco1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL enp_low_hold: q1=%h rco1=%b expected q1=f rco1=1", q1, rco1);
    end
    #2 ENT = 1'b0;
    #1;
    vectors++;
    if (rco1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ent_low_rco: rco1=%b expected 0", rco1);
    end
    ENT = 1'b1;
    #1;
    vectors++;
    if (rco1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ent_high_rco: rco1=%b expected 1", rco1);
    end
  endtask

  task automatic test_cascade();
    LOADn = 1'b0; ENP = 1'b1; ENT = 1'b1; d2 = 8'h0F;
    cen_pulse();
    vectors++;
    if (q2 !== 8'h0F || rco2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cascade_load_0f: q2=%h rco2=%b expected q2=0f rco2=0", q2, rco2);
    end
    LOADn = 1'b1;
    cen_pulse();
    vectors++;
    if (q2 !== 8'h10) begin
      miscompares++;
      $display("[TB] FAIL cascade_0f_to_10: q2=%h expected 10", q2);
    end
`ifdef TTL74161_TC_STROBE_EN
    vectors++;
    if (tc2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tc_no_wrap: tc2=%b expected 0", tc2);
    end
`endif
    LOADn = 1'b0; d2 = 8'hFF;
    cen_pulse();
    vectors++;
    if (q2 !== 8'hFF || rco2 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cascade_load_ff: q2=%h rco2=%b expected q2=ff rco2=1", q2, rco2);
    end
    LOADn = 1'b1;
    cen_pulse();
    vectors++;
    if (q2 !== 8'h00 || rco2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cascade_ff_to_00: q2=%h rco2=%b expected q2=00 rco2=0", q2, rco2);
    end
`ifdef TTL74161_TC_STROBE_EN
    vectors++;
    if (tc2 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tc_wrap_high: tc2=%b expected 1", tc2);
    end
    @(negedge Clk);
    vectors++;
    if (tc2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tc_one_cycle: tc2=%b expected 0", tc2);
    end
`endif
  endtask

  task automatic test_async_clear();
    LOADn = 1'b0; d1 = 4'h7;
    cen_pulse();
    LOADn = 1'b1;
    vectors++;
    if (q1 !== 4'h7) begin
      miscompares++;
      $display("[TB] FAIL clear_preload_7: q1=%h expected 7", q1);
    end
    #2 CLRn = 1'b0;
    #1;
    vectors++;
    if (q1 !== 4'h0 || q2 !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL clear_async: q1=%h q2=%h expected 0 and 00", q1, q2);
    end
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk);
    vectors++;
    if (q1 !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL clear_beats_cen: q1=%h expected 0", q1);
    end
    CLRn = 1'b1;
    @(negedge Clk) Cen = 1'b0;
    vectors++;
    if (q1 !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL clear_release_no_event: q1=%h expected 0", q1);
    end
    cen_pulse();
    vectors++;
    if (q1 !== 4'h1) begin
      miscompares++;
      $display("[TB] FAIL clear_then_count: q1=%h expected 1", q1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    CLRn = 1'b0; Cen = 1'b0; LOADn = 1'b0; ENP = 1'b1; ENT = 1'b1;
    d1 = 4'hA; d2 = 8'hAA;
    test_reset();
    test_count_wrap();
    test_load_priority();
    test_enables();
    test_cascade();
    test_async_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
